// File: rtl/bram_pkg.sv
// Shared memory-map defaults and writer state encoding
// for the block RAM loaded by the stream writer.
package bram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 251;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bram_stream_writer.sv
// Writes a valid/ready byte stream into BRAM port A
// at sequential addresses from 0, with done/full/count.
module bram_stream_writer
  import bram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(DEPTH - 1);

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] ptr_q;
  logic              acc;
  logic              at_end;
  logic              arm;

  assign acc    = s_valid && s_ready;
  assign at_end = (ptr_q == LAST_ADDR);
  assign arm    = start && (state_q != WRITE);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = WRITE;
      end
      WRITE: begin
        if (acc && (s_last || at_end)) state_d = DONE;
      end
      DONE: begin
        if (start) state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_q == WRITE);
    busy    = (state_q == WRITE);
    done    = (state_q == DONE);
  end

  // Port registers: ena/wea pulse for the one cycle after an accept.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      ena   <= 1'b0;
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
      ptr_q <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      ena <= acc;
      wea <= acc;
      if (arm) begin
        ptr_q <= '0;
        count <= '0;
        full  <= 1'b0;
      end else if (acc) begin
        addra <= ptr_q;
        dina  <= s_data;
        ptr_q <= ptr_q + ADDR_W'(1);
        count <= count + (ADDR_W+1)'(1);
        if (at_end) full <= 1'b1;
      end
    end
  end

endmodule
